// File: rtl/packet_width_translator.sv
// Store-and-forward 32->64 packet width converter. Packets are buffered whole,
// bad/overflowed/truncated packets are rewound out of the buffer, good ones are replayed with their byte length.
`timescale 1ns/1ps
module packet_width_translator #(
  parameter int INPUT_WIDTH    = 32,
  parameter int OUTPUT_WIDTH   = 64,
  parameter int BUF_DEPTH      = 2048,
  parameter int LEN_FIFO_DEPTH = 16
) (
  input  logic                    iclk,
  input  logic                    irst_n,
  input  logic                    ivalid,
  input  logic                    isop,
  input  logic                    ieop,
  input  logic [1:0]              iresidual,
  input  logic [INPUT_WIDTH-1:0]  idata,
  input  logic                    ibad,
  input  logic                    oready,
  output logic                    ovalid,
  output logic                    osop,
  output logic                    oeop,
  output logic [OUTPUT_WIDTH-1:0] odata,
  output logic                    odebug_half_polarity,
  output logic [13:0]             oplen,
  output logic                    obad,
  output logic                    ocpu_interrupt
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int FW = $clog2(LEN_FIFO_DEPTH);
  localparam int LW = 14;

  typedef struct packed {
    logic [AW-1:0] start;
    logic [AW:0]   cnt;
    logic [LW-1:0] len;
    logic          half;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  function automatic logic [LW-1:0] sat_add(input logic [LW-1:0] a, input logic [2:0] b);
    logic [LW:0] s;
    s = {1'b0, a} + {{(LW-2){1'b0}}, b};
    return s[LW] ? {LW{1'b1}} : s[LW-1:0];
  endfunction

  logic [OUTPUT_WIDTH-1:0] mem [BUF_DEPTH];
  desc_t                   dmem [LEN_FIFO_DEPTH];

  // ingress state
  logic [AW:0]            wptr, start_ptr, rptr;
  logic                   pkt_open, drop_mode, hold_vld, bad_acc;
  logic [INPUT_WIDTH-1:0] hold_word;
  logic [LW-1:0]          len_acc;

  logic [AW:0]            n_wptr, n_start, used;
  logic                   n_open, n_drop, n_hold_vld, n_bad, take, half;
  logic [INPUT_WIDTH-1:0] n_hold;
  logic [LW-1:0]          n_len;
  logic [2:0]             add_b;
  logic                   wr_en, push, drop_pulse;
  logic [AW-1:0]          wr_addr;
  logic [OUTPUT_WIDTH-1:0] wr_data;
  desc_t                  push_desc;

  // descriptor fifo
  logic [FW:0] dwp, drp;
  logic        dfull, dempty, pop;
  desc_t       dtop;

  assign dfull  = (dwp - drp) == (FW+1)'(LEN_FIFO_DEPTH);
  assign dempty = (dwp == drp);
  assign dtop   = dmem[drp[FW-1:0]];

  always_comb begin
    n_wptr     = wptr;
    n_start    = start_ptr;
    n_open     = pkt_open;
    n_drop     = drop_mode;
    n_hold_vld = hold_vld;
    n_hold     = hold_word;
    n_len      = len_acc;
    n_bad      = bad_acc;
    take       = 1'b0;
    half       = 1'b0;
    add_b      = 3'd4;
    used       = '0;
    wr_en      = 1'b0;
    wr_addr    = wptr[AW-1:0];
    wr_data    = '0;
    push       = 1'b0;
    push_desc  = '0;
    drop_pulse = 1'b0;
    if (ivalid) begin
      if (isop) begin
        // a new sop while a packet is still open means its eop went missing
        if (pkt_open) begin
          n_wptr     = start_ptr;
          drop_pulse = 1'b1;
        end
        n_drop     = 1'b0;
        n_open     = 1'b1;
        n_start    = n_wptr;
        n_hold_vld = 1'b0;
        n_len      = '0;
        n_bad      = 1'b0;
        take       = 1'b1;
      end else if (drop_mode) begin
        if (ieop) n_drop = 1'b0;
      end else if (pkt_open) begin
        n_bad = bad_acc | ibad;
        take  = 1'b1;
      end
    end
    if (take) begin
      if (ieop && iresidual != 2'd0) add_b = {1'b0, iresidual};
      n_len = sat_add(n_len, add_b);
      if (!n_hold_vld && !ieop) begin
        n_hold_vld = 1'b1;
        n_hold     = idata;
      end else begin
        used = n_wptr - rptr;
        if (used == (AW+1)'(BUF_DEPTH)) begin
          // buffer full: forget the packet and swallow the rest of it
          n_wptr     = n_start;
          drop_pulse = 1'b1;
          n_open     = 1'b0;
          n_drop     = !ieop;
          n_hold_vld = 1'b0;
        end else begin
          half       = !n_hold_vld;
          wr_en      = 1'b1;
          wr_addr    = n_wptr[AW-1:0];
          wr_data    = n_hold_vld ? {n_hold, idata} : {idata, {INPUT_WIDTH{1'b0}}};
          n_wptr     = n_wptr + 1'b1;
          n_hold_vld = 1'b0;
          if (ieop) begin
            n_open = 1'b0;
            if (n_bad || dfull) begin
              n_wptr     = n_start;
              drop_pulse = 1'b1;
            end else begin
              push      = 1'b1;
              push_desc = '{start: n_start[AW-1:0], cnt: n_wptr - n_start, len: n_len, half: half};
            end
          end
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      wptr           <= '0;
      start_ptr      <= '0;
      pkt_open       <= 1'b0;
      drop_mode      <= 1'b0;
      hold_vld       <= 1'b0;
      hold_word      <= '0;
      len_acc        <= '0;
      bad_acc        <= 1'b0;
      dwp            <= '0;
      ocpu_interrupt <= 1'b0;
    end else begin
      wptr           <= n_wptr;
      start_ptr      <= n_start;
      pkt_open       <= n_open;
      drop_mode      <= n_drop;
      hold_vld       <= n_hold_vld;
      hold_word      <= n_hold;
      len_acc        <= n_len;
      bad_acc        <= n_bad;
      ocpu_interrupt <= drop_pulse;
      if (push) dwp <= dwp + 1'b1;
    end
  end

  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (push)  dmem[dwp[FW-1:0]] <= push_desc;
  end

  // egress
  state_t        state, n_state;
  logic [AW-1:0] raddr;
  logic [AW:0]   left;
  logic          first, cur_half, issue;
  logic [LW-1:0] cur_len;

  assign issue = (state == S_SEND) && (!ovalid || oready);
  assign pop   = (state == S_LOAD);
  assign obad  = 1'b0;

  always_comb begin
    n_state = state;
    case (state)
      S_IDLE: if (!dempty) n_state = S_LOAD;
      S_LOAD: n_state = S_SEND;
      S_SEND: if (issue && left == (AW+1)'(1)) n_state = dempty ? S_IDLE : S_LOAD;
      default: n_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state                <= S_IDLE;
      drp                  <= '0;
      raddr                <= '0;
      left                 <= '0;
      first                <= 1'b0;
      cur_half             <= 1'b0;
      cur_len              <= '0;
      rptr                 <= '0;
      ovalid               <= 1'b0;
      osop                 <= 1'b0;
      oeop                 <= 1'b0;
      odata                <= '0;
      odebug_half_polarity <= 1'b0;
      oplen                <= '0;
    end else begin
      state <= n_state;
      if (pop) begin
        drp      <= drp + 1'b1;
        raddr    <= dtop.start;
        left     <= dtop.cnt;
        cur_len  <= dtop.len;
        cur_half <= dtop.half;
        first    <= 1'b1;
      end
      // output stage only reloads once the held beat is gone, so o* stay stable under stall
      if (issue) begin
        odata                <= mem[raddr];
        osop                 <= first;
        oeop                 <= (left == (AW+1)'(1));
        odebug_half_polarity <= (left == (AW+1)'(1)) && cur_half;
        oplen                <= cur_len;
        raddr                <= raddr + 1'b1;
        left                 <= left - 1'b1;
        first                <= 1'b0;
        ovalid               <= 1'b1;
      end else if (ovalid && oready) begin
        ovalid <= 1'b0;
      end
      if (ovalid && oready) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_packet_width_translator.sv
// Directed bench for packet_width_translator: expected beats are queued per packet and checked as accepted.
`timescale 1ns/1ps
module tb_packet_width_translator;
  logic        iclk = 1'b0, irst_n = 1'b1;
  logic        ivalid = 0, isop = 0, ieop = 0, ibad = 0, oready = 0;
  logic [1:0]  iresidual = 0;
  logic [31:0] idata = 0;
  logic        ovalid, osop, oeop, odebug_half_polarity, obad, ocpu_interrupt;
  logic [63:0] odata;
  logic [13:0] oplen;

  packet_width_translator dut (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isop(isop), .ieop(ieop),
    .iresidual(iresidual), .idata(idata), .ibad(ibad), .oready(oready),
    .ovalid(ovalid), .osop(osop), .oeop(oeop), .odata(odata),
    .odebug_half_polarity(odebug_half_polarity), .oplen(oplen), .obad(obad),
    .ocpu_interrupt(ocpu_interrupt)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [63:0] d;
    logic        sop, eop, half;
    logic [13:0] len;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       cur, held;
  int          n_tests = 0, n_fail = 0, irq_cnt = 0, rx_cnt = 0, ready_mode = 1;
  logic [13:0] last_len = 0;
  logic [63:0] first_data = 0, last_data = 0;
  bit          stalled = 0;

  assign cur = {odata, osop, oeop, odebug_half_polarity, oplen};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge iclk) begin
    if (irst_n) begin
      if (ocpu_interrupt) irq_cnt++;
      if (stalled && ovalid) chk("hold_stable", cur, held);
      if (ovalid && oready) begin
        rx_cnt++;
        if (osop) begin last_len = oplen; first_data = odata; end
        last_data = odata;
        chk("obad", obad, 0);
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat", cur, exp_q.pop_front());
      end
      stalled = ovalid && !oready;
      held    = cur;
    end else stalled = 0;
  end

  initial forever begin
    @(posedge iclk); #1;
    case (ready_mode)
      0: oready = 1'b0;
      1: oready = 1'b1;
      default: oready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    ivalid = 0; isop = 0; ieop = 0; ibad = 0; iresidual = 0;
    repeat (n) begin @(posedge iclk); #1; end
  endtask

  task automatic send_pkt(input int nw, input int res, input bit bad, input bit ok,
                          input logic [7:0] id, input bit no_eop = 0);
    beat_t b;
    for (int i = 0; i < nw; i++) begin
      ivalid = 1; isop = (i == 0); ieop = (i == nw - 1) && !no_eop;
      iresidual = (i == nw - 1) ? res[1:0] : 2'd0;
      idata = {id, 24'(i)}; ibad = bad && (i > 0);
      @(posedge iclk); #1;
    end
    ivalid = 0; isop = 0; ieop = 0; ibad = 0; iresidual = 0;
    if (ok) for (int k = 0; k < nw; k += 2) begin
      b.d    = {{id, 24'(k)}, (k + 1 < nw) ? {id, 24'(k + 1)} : 32'h0};
      b.sop  = (k == 0);
      b.eop  = (k + 2 >= nw);
      b.half = (k + 1 >= nw);
      b.len  = 14'(4 * (nw - 1) + (res == 0 ? 4 : res));
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int maxc, input string tag);
    int c = 0;
    while (exp_q.size() != 0 && c < maxc) begin @(posedge iclk); #1; c++; end
    chk({"drain_", tag}, exp_q.size(), 0);
    exp_q.delete();
    idle(6);
  endtask

  int irq0, rx0;

  initial begin
    #1 irst_n = 0;
    idle(3);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_odata", odata, 0);
    chk("rst_oplen", oplen, 0);
    chk("rst_irq", ocpu_interrupt, 0);
    irst_n = 1;
    idle(2);

    // 64-byte packet
    send_pkt(16, 0, 0, 1, 8'hA0);
    wait_drain(200, "t1");
    chk("t1_len", last_len, 64);
    chk("t1_rx", rx_cnt, 8);
    chk("t1_first", first_data, 64'hA0000000_A0000001);
    chk("t1_last", last_data, 64'hA000000E_A000000F);

    // stray word with no open packet must vanish
    ivalid = 1; idata = 32'hDEADBEEF; @(posedge iclk); #1;
    idle(2);

    // 66-byte packet, odd word count
    rx0 = rx_cnt;
    send_pkt(17, 2, 0, 1, 8'hB0);
    wait_drain(200, "t2");
    chk("t2_len", last_len, 66);
    chk("t2_rx", rx_cnt - rx0, 9);
    chk("t2_last", last_data, 64'hB0000010_00000000);

    // bad packet dropped, next good packet intact
    irq0 = irq_cnt; rx0 = rx_cnt;
    send_pkt(10, 0, 1, 0, 8'hC0);
    idle(10);
    chk("t3_irq", irq_cnt - irq0, 1);
    chk("t3_rx", rx_cnt - rx0, 0);
    send_pkt(5, 3, 0, 1, 8'hC1);
    wait_drain(200, "t3");
    chk("t3_len", last_len, 19);

    // missing eop: open packet dropped by the next sop
    irq0 = irq_cnt;
    send_pkt(5, 0, 0, 0, 8'hD0, 1);
    send_pkt(8, 1, 0, 1, 8'hD1);
    wait_drain(200, "t4");
    chk("t4_irq", irq_cnt - irq0, 1);
    chk("t4_len", last_len, 29);

    // jumbo then small, random backpressure
    ready_mode = 2;
    send_pkt(2304, 0, 0, 1, 8'hE0);
    send_pkt(25, 0, 0, 1, 8'hE1);
    wait_drain(20000, "t5");
    chk("t5_len", last_len, 100);
    ready_mode = 1;
    idle(2);

    // descriptor fifo full: two popped + 16 queued accepted, rest dropped
    ready_mode = 0;
    irq0 = irq_cnt;
    for (int i = 0; i < 20; i++) begin
      send_pkt(1, i % 4, 0, i < 18, 8'(8'h10 + i));
      idle(1);
    end
    idle(4);
    chk("t6_irq", irq_cnt - irq0, 2);
    ready_mode = 1;
    wait_drain(500, "t6");

    // buffer overflow on the second jumbo while output stalled
    ready_mode = 0;
    irq0 = irq_cnt;
    send_pkt(2304, 0, 0, 1, 8'h70);
    send_pkt(2304, 0, 0, 0, 8'h71);
    idle(5);
    chk("t7_irq", irq_cnt - irq0, 1);
    ready_mode = 1;
    wait_drain(5000, "t7a");
    send_pkt(4, 0, 0, 1, 8'h72);
    wait_drain(200, "t7b");
    chk("t7_len", last_len, 16);

    // reset mid-packet with a beat stuck on the output
    ready_mode = 0;
    send_pkt(4, 0, 0, 0, 8'h80);
    idle(6);
    chk("t8_pre_ovalid", ovalid, 1);
    send_pkt(3, 0, 0, 0, 8'h81, 1);
    irst_n = 0;
    #1;
    chk("t8_rst_ovalid", ovalid, 0);
    chk("t8_rst_odata", odata, 0);
    chk("t8_rst_oplen", oplen, 0);
    exp_q.delete();
    idle(2);
    irst_n = 1;
    ready_mode = 1;
    idle(2);
    rx0 = rx_cnt;
    ivalid = 1; idata = 32'h81000003; @(posedge iclk); #1;
    ieop = 1; idata = 32'h81000004; @(posedge iclk); #1;
    idle(3);
    send_pkt(6, 1, 0, 1, 8'h82);
    wait_drain(200, "t8");
    chk("t8_rx", rx_cnt - rx0, 3);
    chk("t8_len", last_len, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
